// File: rtl/rca_pkg.sv
// Shared constants for the approximate-RCA error monitor: default widths,
// the carry guard used by the saturating accumulators, and the FSM encoding.
package rca_pkg;

   localparam int RCA_WIDTH = 9;
   localparam int RCA_CNT_W = 16;
   localparam int RCA_ACC_W = 26;

   // One extra carry bit on an unsigned accumulator sum exposes overflow,
   // which the accumulator turns into saturation at all-ones.
   localparam int RCA_SAT_GUARD = 1;

   // FSM encoding (IDLE, RUN, DRAIN, DONE)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rca_err_stat_acc.sv
// Stage-2 statistics bank for the RCA error monitor: error count,
// saturating error-distance sum, maximum error distance and, when
// RCA_ERR_BIAS_EN is defined, a signed bias sum saturating at both limits.
module rca_err_stat_acc
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH,
   parameter int CNT_W = RCA_CNT_W,
   parameter int ACC_W = RCA_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    upd_i,
   input  logic                    err_i,
   input  logic [WIDTH:0]          ed_i,
`ifdef RCA_ERR_BIAS_EN
   input  logic signed [WIDTH+1:0] diff_i,
   output logic signed [ACC_W:0]   ed_bias_o,
`endif
   output logic [CNT_W-1:0]        n_err_o,
   output logic [ACC_W-1:0]        ed_sum_o,
   output logic [WIDTH:0]          ed_max_o
);

   logic [CNT_W-1:0]               n_err_q,  n_err_d;
   logic [ACC_W-1:0]               ed_sum_q, ed_sum_d;
   logic [WIDTH:0]                 ed_max_q, ed_max_d;
   logic [ACC_W+RCA_SAT_GUARD-1:0] sum_w;

   // Next-state for count, saturating sum and running maximum; clear wins.
   always_comb begin
      sum_w    = {{RCA_SAT_GUARD{1'b0}}, ed_sum_q} + (ACC_W+RCA_SAT_GUARD)'(ed_i);
      n_err_d  = n_err_q;
      ed_sum_d = ed_sum_q;
      ed_max_d = ed_max_q;
      if (clr_i) begin
         n_err_d  = '0;
         ed_sum_d = '0;
         ed_max_d = '0;
      end else if (upd_i) begin
         // Window length is below 2^CNT_W, so the count cannot wrap.
         n_err_d  = n_err_q + CNT_W'(err_i);
         ed_sum_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
         ed_max_d = (ed_i > ed_max_q) ? ed_i : ed_max_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_err_q  <= '0;
         ed_sum_q <= '0;
         ed_max_q <= '0;
      end else begin
         n_err_q  <= n_err_d;
         ed_sum_q <= ed_sum_d;
         ed_max_q <= ed_max_d;
      end
   end

   assign n_err_o  = n_err_q;
   assign ed_sum_o = ed_sum_q;
   assign ed_max_o = ed_max_q;

`ifdef RCA_ERR_BIAS_EN
   logic signed [ACC_W:0]   bias_q, bias_d;
   logic signed [ACC_W+1:0] bsum_w;

   // Signed bias next-state; the extra top bit detects overflow in either direction.
   always_comb begin
      bsum_w = {bias_q[ACC_W], bias_q} + {{(ACC_W-WIDTH){diff_i[WIDTH+1]}}, diff_i};
      bias_d = bias_q;
      if (clr_i) begin
         bias_d = '0;
      end else if (upd_i) begin
         if (bsum_w[ACC_W+1] != bsum_w[ACC_W]) begin
            bias_d = bsum_w[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
         end else begin
            bias_d = bsum_w[ACC_W:0];
         end
      end
   end

   // Bias register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_q <= '0;
      end else begin
         bias_q <= bias_d;
      end
   end

   assign ed_bias_o = bias_q;
`endif

endmodule

// File: rtl/rca_error_monitor.sv
// Accuracy monitor for the approximate ripple-carry adder. Recomputes the
// exact sum of each accepted A/B pair, compares it with the adder's S and
// accumulates error statistics over a programmable window.
// Optional feature macro: RCA_ERR_BIAS_EN adds the signed ed_bias output.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until `window` have transferred
// DRAIN | last sample accepted, waiting for stage 1 to empty
// DONE  | statistics final and held; start reopens a window
module rca_error_monitor
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH,
   parameter int CNT_W = RCA_CNT_W,
   parameter int ACC_W = RCA_ACC_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_W-1:0]      window,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      A,
   input  logic [WIDTH-1:0]      B,
   input  logic [WIDTH:0]        S,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      n_err,
   output logic [ACC_W-1:0]      ed_sum,
`ifdef RCA_ERR_BIAS_EN
   output logic signed [ACC_W:0] ed_bias,
`endif
   output logic [WIDTH:0]        ed_max
);

   logic [1:0]              state_q,    state_d;
   logic [CNT_W-1:0]        window_q,   window_d;
   logic [CNT_W-1:0]        accepted_q, accepted_d;
   logic                    done_q,     done_d;
   logic                    start_ok;
   logic                    xfer;

   logic [WIDTH:0]          exact_w;
   logic signed [WIDTH+1:0] diff_w;
   logic [WIDTH:0]          ed_w;

   logic                    s1_valid_q;
   logic                    s1_err_q;
   logic [WIDTH:0]          s1_ed_q;

   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign in_ready = (state_q == ST_RUN) && (accepted_q < window_q);
   assign xfer     = in_valid && in_ready;
   assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done     = done_q;

   // Window sequencing; start is only honoured between windows.
   always_comb begin
      state_d    = state_q;
      window_d   = window_q;
      accepted_d = accepted_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               window_d   = window;
               accepted_d = '0;
               if (window == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               accepted_d = accepted_q + CNT_W'(1);
               if (accepted_d == window_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Once stage 1 is empty the final stage-2 update lands this edge,
            // so done is raised for the cycle after it.
            if (!s1_valid_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and window bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         window_q   <= '0;
         accepted_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         window_q   <= window_d;
         accepted_q <= accepted_d;
         done_q     <= done_d;
      end
   end

   // Exact sum and error distance of the sample on the input port.
   always_comb begin
      exact_w = {1'b0, A} + {1'b0, B};
      diff_w  = {1'b0, exact_w} - {1'b0, S};
      ed_w    = diff_w[WIDTH+1] ? (WIDTH+1)'(-diff_w) : diff_w[WIDTH:0];
   end

   // Stage 1: capture the per-sample result on each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_ed_q    <= '0;
      end else begin
         s1_valid_q <= xfer;
         if (xfer) begin
            s1_err_q <= (diff_w != '0);
            s1_ed_q  <= ed_w;
         end
      end
   end

`ifdef RCA_ERR_BIAS_EN
   logic signed [WIDTH+1:0] s1_diff_q;

   // Stage 1 signed difference, only needed for the bias sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_diff_q <= '0;
      end else if (xfer) begin
         s1_diff_q <= diff_w;
      end
   end
`endif

   rca_err_stat_acc #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
   ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (start_ok),
      .upd_i     (s1_valid_q),
      .err_i     (s1_err_q),
      .ed_i      (s1_ed_q),
`ifdef RCA_ERR_BIAS_EN
      .diff_i    (s1_diff_q),
      .ed_bias_o (ed_bias),
`endif
      .n_err_o   (n_err),
      .ed_sum_o  (ed_sum),
      .ed_max_o  (ed_max)
   );

endmodule

// File: tb/tb_rca_error_monitor.sv
// Self-checking bench for rca_error_monitor. A second instance with a 10-bit
// accumulator shares all inputs and exercises saturation.
module tb_rca_error_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] window;
   logic        in_valid;
   logic [8:0]  A, B;
   logic [9:0]  S;

   logic        in_ready, busy, done;
   logic [15:0] n_err;
   logic [25:0] ed_sum;
   logic [9:0]  ed_max;
   logic        in_ready_s, busy_s, done_s;
   logic [15:0] n_err_s;
   logic [9:0]  ed_sum_s;
   logic [9:0]  ed_max_s;
`ifdef RCA_ERR_BIAS_EN
   logic [26:0] ed_bias;
   logic [10:0] ed_bias_s;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int qa[$], qb[$], qs[$];
   longint exp_nerr, exp_sum, exp_sum_s, exp_max, exp_bias, exp_bias_s;

   typedef struct {
      int a;
      int b;
      int s;
      int exp_err;
      int exp_ed;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rca_error_monitor dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .window   (window),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .S        (S),
      .busy     (busy),
      .done     (done),
      .n_err    (n_err),
      .ed_sum   (ed_sum),
`ifdef RCA_ERR_BIAS_EN
      .ed_bias  (ed_bias),
`endif
      .ed_max   (ed_max)
   );

   rca_error_monitor #(.ACC_W(10)) dut_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .window   (window),
      .in_valid (in_valid),
      .in_ready (in_ready_s),
      .A        (A),
      .B        (B),
      .S        (S),
      .busy     (busy_s),
      .done     (done_s),
      .n_err    (n_err_s),
      .ed_sum   (ed_sum_s),
`ifdef RCA_ERR_BIAS_EN
      .ed_bias  (ed_bias_s),
`endif
      .ed_max   (ed_max_s)
   );

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: statistics straight from the definitions over the queued samples.
   task automatic model(input int n);
      longint d, ad;
      exp_nerr = 0; exp_sum = 0; exp_sum_s = 0; exp_max = 0; exp_bias = 0; exp_bias_s = 0;
      for (int i = 0; i < n; i++) begin
         d  = longint'(qa[i] + qb[i]) - longint'(qs[i]);
         ad = (d < 0) ? -d : d;
         if (d != 0) exp_nerr++;
         exp_sum   = exp_sum + ad;
         if (exp_sum > 64'd67108863) exp_sum = 64'd67108863;
         exp_sum_s = exp_sum_s + ad;
         if (exp_sum_s > 1023) exp_sum_s = 1023;
         if (ad > exp_max) exp_max = ad;
         exp_bias   = exp_bias + d;
         if (exp_bias > 67108863) exp_bias = 67108863;
         if (exp_bias < -67108864) exp_bias = -67108864;
         exp_bias_s = exp_bias_s + d;
         if (exp_bias_s > 1023) exp_bias_s = 1023;
         if (exp_bias_s < -1024) exp_bias_s = -1024;
      end
   endtask

   task automatic check_stats(input string tag);
      check({tag, ".n_err"},    longint'(n_err),    exp_nerr);
      check({tag, ".ed_sum"},   longint'(ed_sum),   exp_sum);
      check({tag, ".ed_max"},   longint'(ed_max),   exp_max);
      check({tag, ".sat_sum"},  longint'(ed_sum_s), exp_sum_s);
      check({tag, ".sat_nerr"}, longint'(n_err_s),  exp_nerr);
`ifdef RCA_ERR_BIAS_EN
      check({tag, ".ed_bias"},  longint'($signed(ed_bias)),   exp_bias);
      check({tag, ".sat_bias"}, longint'($signed(ed_bias_s)), exp_bias_s);
`endif
   endtask

   task automatic do_start(input int win);
      @(negedge clk);
      window = win[15:0];
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Offer one sample after `gap` idle cycles; xcyc is the cycle it transferred in.
   task automatic send(input int a, input int b, input int s, input int gap, output int xcyc);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      A = a[8:0]; B = b[8:0]; S = s[9:0];
      in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (in_ready) begin
            xcyc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      xcyc = cyc;
      in_valid = 1'b0;
      check("send_timeout", 0, 1);
   endtask

   task automatic wait_done(output int dcyc);
      dcyc = -1;
      for (int t = 0; t < 100; t++) begin
         if (done) begin
            dcyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (dcyc < 0) check("done_timeout", 0, 1);
      @(negedge clk);
      check("done_pulse_width", longint'(done), 0);
   endtask

   // Run a full window over the queued samples and compare against the model.
   task automatic run_window(input int win, input int maxgap, input string tag);
      int xc, dc;
      xc = 0;
      do_start(win);
      check({tag, ".busy"}, longint'(busy), 1);
      for (int i = 0; i < win; i++)
         send(qa[i], qb[i], qs[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, xc);
      wait_done(dc);
      check({tag, ".latency"}, longint'(dc - xc), 3);
      check({tag, ".ready_after"}, longint'(in_ready), 0);
      model(win);
      check_stats(tag);
   endtask

   task automatic load(input int a, input int b, input int s);
      qa.push_back(a); qb.push_back(b); qs.push_back(s);
   endtask

   task automatic clearq();
      qa.delete(); qb.delete(); qs.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int xc, nx, nd, win, mode, ex, sv;

      vt[0] = '{a:0,   b:0,   s:1,    exp_err:1, exp_ed:1};
      vt[1] = '{a:511, b:0,   s:0,    exp_err:1, exp_ed:511};
      vt[2] = '{a:511, b:511, s:0,    exp_err:1, exp_ed:1022};
      vt[3] = '{a:3,   b:4,   s:7,    exp_err:0, exp_ed:0};
      vt[4] = '{a:100, b:27,  s:128,  exp_err:1, exp_ed:1};
      vt[5] = '{a:256, b:256, s:0,    exp_err:1, exp_ed:512};
      vt[6] = '{a:0,   b:0,   s:1023, exp_err:1, exp_ed:1023};
      vt[7] = '{a:511, b:511, s:1022, exp_err:0, exp_ed:0};

      rst_n = 1'b0; start = 1'b0; window = '0; in_valid = 1'b0;
      A = '0; B = '0; S = '0;
      repeat (3) @(negedge clk);
      check("rst.in_ready", longint'(in_ready), 0);
      check("rst.busy",     longint'(busy),     0);
      check("rst.done",     longint'(done),     0);
      check("rst.n_err",    longint'(n_err),    0);
      check("rst.ed_sum",   longint'(ed_sum),   0);
      check("rst.ed_max",   longint'(ed_max),   0);
      rst_n = 1'b1;

      // 1: exact samples only
      clearq();
      load(0, 0, 0); load(100, 200, 300); load(511, 511, 1022); load(1, 2, 3);
      run_window(4, 0, "t1");
      check("t1.n_err_const",  longint'(n_err),  0);
      check("t1.ed_sum_const", longint'(ed_sum), 0);

      // 2: mixed errors
      clearq();
      load(15, 1, 0); load(7, 9, 20); load(255, 0, 255);
      run_window(3, 0, "t2");
      check("t2.n_err_const",  longint'(n_err),  2);
      check("t2.ed_sum_const", longint'(ed_sum), 20);
      check("t2.ed_max_const", longint'(ed_max), 16);
`ifdef RCA_ERR_BIAS_EN
      check("t2.bias_const", longint'($signed(ed_bias)), 12);
`endif

      // 3: window=2 with in_valid held for 5 cycles
      do_start(2);
      nx = 0; nd = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 5);
         if (i == 0)      begin A = 9'd1;   B = 9'd1; S = 10'd2; end
         else if (i == 1) begin A = 9'd5;   B = 9'd5; S = 10'd9; end
         else             begin A = 9'd500; B = 9'd0; S = 10'd0; end
         if (in_valid && in_ready) nx++;
         if (done) nd++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t3.transfers",  nx, 2);
      check("t3.done_count", nd, 1);
      check("t3.in_ready",   longint'(in_ready), 0);
      check("t3.n_err",      longint'(n_err),    1);
      check("t3.ed_sum",     longint'(ed_sum),   1);
      check("t3.ed_max",     longint'(ed_max),   1);

      // 4: window=0 from DONE with stale statistics
      nx = 0;
      do_start(0);
      check("t4.done_next", longint'(done),   1);
      check("t4.n_err",     longint'(n_err),  0);
      check("t4.ed_sum",    longint'(ed_sum), 0);
      check("t4.ed_max",    longint'(ed_max), 0);
      check("t4.busy",      longint'(busy),   0);
      for (int i = 0; i < 3; i++) begin
         if (in_ready) nx++;
         @(negedge clk);
      end
      check("t4.ready_never", nx, 0);

      // 5: reset mid-window after 3 of 8 samples
      do_start(8);
      send(10, 10, 0, 0, xc);
      send(1, 1, 5, 0, xc);
      send(2, 2, 4, 0, xc);
      rst_n = 1'b0;
      #1;
      check("t5.n_err",    longint'(n_err),    0);
      check("t5.ed_sum",   longint'(ed_sum),   0);
      check("t5.ed_max",   longint'(ed_max),   0);
      check("t5.busy",     longint'(busy),     0);
      check("t5.in_ready", longint'(in_ready), 0);
      check("t5.done",     longint'(done),     0);
      @(negedge clk);
      rst_n = 1'b1;
      clearq();
      load(300, 100, 390);
      run_window(1, 0, "t5b");

      // 6: saturation of the 10-bit accumulator
      clearq();
      repeat (4) load(0, 0, 511);
      run_window(4, 0, "t6");
      check("t6.sat_sum_const", longint'(ed_sum_s), 1023);
      check("t6.sat_max",       longint'(ed_max_s), 511);
      check("t6.sat_nerr",      longint'(n_err_s),  4);
      check("t6.full_sum",      longint'(ed_sum),   2044);

      // Single-sample windows from the vector table
      for (int k = 0; k < 8; k++) begin
         do_start(1);
         send(vt[k].a, vt[k].b, vt[k].s, 0, xc);
         wait_done(nd);
         check($sformatf("vec%0d.n_err", k),  longint'(n_err),  vt[k].exp_err);
         check($sformatf("vec%0d.ed_sum", k), longint'(ed_sum), vt[k].exp_ed);
         check($sformatf("vec%0d.ed_max", k), longint'(ed_max), vt[k].exp_ed);
      end

      // Random windows against the model
      for (int r = 0; r < 25; r++) begin
         clearq();
         win = $urandom_range(1, 6);
         for (int i = 0; i < win; i++) begin
            qa.push_back($urandom_range(0, 511));
            qb.push_back($urandom_range(0, 511));
            ex   = qa[i] + qb[i];
            mode = $urandom_range(0, 2);
            if (mode == 0) sv = ex;
            else if (mode == 1) sv = ex + int'($urandom_range(0, 8)) - 4;
            else sv = $urandom_range(0, 1023);
            if (sv < 0) sv = 0;
            if (sv > 1023) sv = 1023;
            qs.push_back(sv);
         end
         run_window(win, 2, $sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
